// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared constants for the nibble-serial add/subtract sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package addsub_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Counter width for a nibble index; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_addsub
//  Description : Combinational 4-bit ripple slice of full-adder cells; exposes
//                the carry into its MSB for signed-overflow detection.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_addsub
    import addsub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b_x,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [NIB_W:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < NIB_W; i++) begin : g_fa
            assign s[i]     = a[i] ^ b_x[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b_x[i]) | (w_c[i] & (a[i] ^ b_x[i]));
        end
    endgenerate

    assign cout  = w_c[NIB_W];
    assign c_msb = w_c[NIB_W-1];

endmodule
`default_nettype wire

// File: rtl/addsub_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_seq_ctrl
//  Description : Multi-precision add/subtract sequencer driving one shared
//                4-bit slice, LSB nibble first, with chained carry.
//  Revision    : 1.0  initial release
// ============================================================================
module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("addsub_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic             m_q,       m_d;
    logic             carry_q,   carry_d;
    logic [IDX_W-1:0] nib_idx_q, nib_idx_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             cout_q,    cout_d;
    logic             ovf_q,     ovf_d;

    logic [IDX_W+1:0] w_base;
    logic [NIB_W-1:0] w_a_nib;
    logic [NIB_W-1:0] w_b_x;
    logic [NIB_W-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;

    // Bit offset of the active nibble is simply nib_idx * 4.
    assign w_base  = {nib_idx_q, 2'b00};
    assign w_a_nib = a_q[w_base +: NIB_W];
    assign w_b_x   = b_q[w_base +: NIB_W] ^ {NIB_W{m_q}};

    nibble_addsub u_slice (
        .a     (w_a_nib),
        .b_x   (w_b_x),
        .cin   (carry_q),
        .s     (w_sum),
        .cout  (w_cout),
        .c_msb (w_c_msb)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        carry_d   = carry_q;
        nib_idx_d = nib_idx_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    m_d       = m;
                    carry_d   = m;
                    nib_idx_d = '0;
                    result_d  = '0;
                    cout_d    = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[w_base +: NIB_W] = w_sum;
                carry_d   = w_cout;
                nib_idx_d = nib_idx_q + 1'b1;
                if (nib_idx_q == c_last_idx) begin
                    cout_d  = w_cout;
                    ovf_d   = w_c_msb ^ w_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= 1'b0;
            carry_q   <= 1'b0;
            nib_idx_q <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            carry_q   <= carry_d;
            nib_idx_q <= nib_idx_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_seq_ctrl
//  Description : Scoreboard bench for addsub_seq_ctrl at WIDTH=16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_addsub_seq_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        int               due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             m = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, cout, overflow;
    logic [WIDTH-1:0] result;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    addsub_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .m        (m),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop expectation on every done, and check pulse width and busy span.
    logic prev_done = 1'b0;
    int   span      = 0;
    logic saw_done  = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",   32'(result),   32'(e.r));
                check("cout",     32'(cout),     32'(e.c));
                check("overflow", 32'(overflow), 32'(e.v));
                check("done_cycle", 32'(cyc),    32'(e.due));
            end
            check("done_width", 32'(prev_done), 32'd0);
            saw_done = 1'b1;
        end
        prev_done = (done === 1'b1);
        if (busy === 1'b1) begin
            span++;
        end else if (span != 0) begin
            if (saw_done) check("busy_span", 32'(span), 32'(NIBBLES + 1));
            span     = 0;
            saw_done = 1'b0;
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic im,
                      input logic [WIDTH-1:0] er, input logic ec, input logic ev, input bit glitch);
        exp_t e;
        wait_idle();
        a = ia; b = ib; m = im; start = 1'b1;
        e.r = er; e.c = ec; e.v = ev; e.due = cyc + 1 + NIBBLES;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib; m = ~im;
        if (glitch) begin
            @(negedge clk);
            start = 1'b1; a = 16'hFFFF;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic rand_op();
        logic [WIDTH-1:0] ra, rb, bx;
        logic             rm;
        logic [WIDTH:0]   full;
        ra   = WIDTH'($urandom);
        rb   = WIDTH'($urandom);
        rm   = 1'($urandom_range(1, 0));
        bx   = rb ^ {WIDTH{rm}};
        full = {1'b0, ra} + {1'b0, bx} + {{WIDTH{1'b0}}, rm};
        op(ra, rb, rm, full[WIDTH-1:0], full[WIDTH],
           (ra[WIDTH-1] == bx[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]), 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   32'(busy),     32'd0);
        check("rst_done",   32'(done),     32'd0);
        check("rst_result", 32'(result),   32'd0);
        check("rst_cout",   32'(cout),     32'd0);
        check("rst_ovf",    32'(overflow), 32'd0);

        op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
        op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        op(16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        op(16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0, 1'b1);

        // Abort an operation with reset during its second RUN cycle.
        wait_idle();
        a = 16'h1111; b = 16'h2222; m = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   32'(busy),     32'd0);
        check("abort_done",   32'(done),     32'd0);
        check("abort_result", 32'(result),   32'd0);
        check("abort_cout",   32'(cout),     32'd0);
        check("abort_ovf",    32'(overflow), 32'd0);
        op(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 2000; i++) rand_op();

        wait_idle();
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
